// File: rtl/program_store.sv
// ---------------------------------------------------------------------------
// program_store
//
// Field-loadable opcode store. Opcodes are shifted in bit-serially (MSB
// first) from the SPI-side loader. The CPU fetch unit reads them back through
// a registered port with 1-cycle latency. Any read at or above the committed
// program length returns NOP_OPCODE. Any read while a load is in progress
// also returns NOP_OPCODE, so a short program falls through to NOPs.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_load_start   pulse: begin (or restart) a program load
//   i_load_strobe  qualifies i_load_bit, one bit per cycle
//   i_load_bit     serial opcode bit, MSB first
//   i_load_done    pulse: end load and commit the program length
//   o_loading      high between load_start and load_done
//   o_load_full    high once DEPTH words were written in the current load
//   o_prog_len     number of committed words
//   i_fetch_req    read request
//   i_fetch_addr   read address
//   o_fetch_valid  registered copy of i_fetch_req
//   o_fetch_data   opcode read (held while no request)
// ---------------------------------------------------------------------------
module program_store #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 4,
    parameter int                    DEPTH      = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = 4'b0111,
    localparam int                   PLW        = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_start,
    input  logic                  i_load_strobe,
    input  logic                  i_load_bit,
    input  logic                  i_load_done,
    output logic                  o_loading,
    output logic                  o_load_full,
    output logic [PLW-1:0]        o_prog_len,
    input  logic                  i_fetch_req,
    input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
    output logic                  o_fetch_valid,
    output logic [DATA_WIDTH-1:0] o_fetch_data
);

    // Storage index width. DEPTH <= 2**ADDR_WIDTH, so IW <= ADDR_WIDTH.
    localparam int IW  = $clog2(DEPTH);
    // Bit counter counts 0 .. DATA_WIDTH-1.
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    // The shift register only needs DATA_WIDTH-1 bits. The final bit of a
    // word comes straight from i_load_bit in the cycle the word is written.
    localparam int SHW = (DATA_WIDTH > 1) ? DATA_WIDTH - 1 : 1;
    // Address compare width: the wider of the fetch address and prog_len.
    localparam int CW  = (ADDR_WIDTH > PLW) ? ADDR_WIDTH : PLW;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [PLW-1:0]        r_wptr;
    logic [BCW-1:0]        r_bitcnt;
    logic [SHW-1:0]        r_shift;
    logic                  r_load_full;
    logic [PLW-1:0]        r_prog_len;
    logic                  r_fetch_valid;
    logic [DATA_WIDTH-1:0] r_fetch_data;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_loading;
    logic                  w_restart;
    logic                  w_commit;
    logic                  w_shift_en;
    logic                  w_last_bit;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_rd_hit;
    logic [IW-1:0]         w_rd_idx;

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority: load_start beats load_done, and load_done beats a strobe
    // in the same cycle. Once the load is full, strobes are ignored, so no
    // write can happen with the write pointer at DEPTH.
    always_comb begin
        w_next_state = r_state;
        w_loading    = (r_state == LOAD);
        w_restart    = 1'b0;
        w_commit     = 1'b0;
        w_shift_en   = 1'b0;
        w_last_bit   = 1'b0;

        if (i_load_start) begin
            w_next_state = LOAD;
            w_restart    = 1'b1;
        end else if (r_state == LOAD) begin
            if (i_load_done) begin
                w_next_state = IDLE;
                w_commit     = 1'b1;
            end else if (i_load_strobe && !r_load_full) begin
                w_shift_en = 1'b1;
                w_last_bit = (r_bitcnt == BCW'(DATA_WIDTH - 1));
            end
        end
    end

    // ------------------------------------------------------------------
    // Serial word assembly
    // ------------------------------------------------------------------
    if (DATA_WIDTH > 1) begin : g_shift
        assign w_word = {r_shift, i_load_bit};
    end else begin : g_single
        assign w_word = i_load_bit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr      <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_load_full <= 1'b0;
            r_prog_len  <= '0;
        end else if (w_restart) begin
            // prog_len keeps the old program until the new one is committed
            r_wptr      <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_load_full <= 1'b0;
        end else if (w_commit) begin
            // A partially shifted word is simply dropped here
            r_prog_len  <= r_wptr;
            r_bitcnt    <= '0;
            r_shift     <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_word[SHW-1:0];
            if (w_last_bit) begin
                r_bitcnt <= '0;
                r_wptr   <= r_wptr + PLW'(1);
                if (r_wptr == PLW'(DEPTH - 1)) begin
                    r_load_full <= 1'b1;
                end
            end else begin
                r_bitcnt <= r_bitcnt + BCW'(1);
            end
        end
    end

    // Storage has no reset. prog_len=0 masks every word after reset.
    always_ff @(posedge i_clk) begin
        if (w_last_bit) begin
            r_mem[r_wptr[IW-1:0]] <= w_word;
        end
    end

    // ------------------------------------------------------------------
    // Fetch port
    // ------------------------------------------------------------------
    // addr < prog_len <= DEPTH guarantees the truncated index is in range
    // whenever the stored word is actually selected.
    assign w_rd_hit = !w_loading && (CW'(i_fetch_addr) < CW'(r_prog_len));
    assign w_rd_idx = i_fetch_addr[IW-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= NOP_OPCODE;
        end else begin
            r_fetch_valid <= i_fetch_req;
            if (i_fetch_req) begin
                r_fetch_data <= w_rd_hit ? r_mem[w_rd_idx] : NOP_OPCODE;
            end
        end
    end

    assign o_loading     = w_loading;
    assign o_load_full   = r_load_full;
    assign o_prog_len    = r_prog_len;
    assign o_fetch_valid = r_fetch_valid;
    assign o_fetch_data  = r_fetch_data;

endmodule

// File: tb/tb_program_store.sv
module tb_program_store;

    localparam int          AW    = 8;
    localparam int          DW    = 4;
    localparam int          DEPTH = 32;
    localparam int          PLW   = $clog2(DEPTH) + 1;
    localparam logic [3:0]  NOP   = 4'b0111;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0, load_strobe = 1'b0, load_bit = 1'b0, load_done = 1'b0;
    logic          loading, load_full;
    logic [PLW-1:0] prog_len;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;

    int n_cmp  = 0;
    int n_fail = 0;

    program_store #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NOP_OPCODE(NOP)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_load_start(load_start), .i_load_strobe(load_strobe),
        .i_load_bit(load_bit), .i_load_done(load_done),
        .o_loading(loading), .o_load_full(load_full), .o_prog_len(prog_len),
        .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .o_fetch_valid(fetch_valid), .o_fetch_data(fetch_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: words of the current load as a list, bits of the
    // partial word as a list, committed program as a snapshot array.
    // ------------------------------------------------------------------
    bit         armed = 0;
    bit         e_loading, e_full, e_valid;
    int         e_plen;
    logic [3:0] e_data;
    int         m_words[$];
    int         m_bits[$];
    int         m_com[DEPTH];

    always @(posedge clk) begin
        if (rst) begin
            armed     = 1;
            e_loading = 0; e_full = 0; e_plen = 0;
            e_valid   = 0; e_data = NOP;
            m_words.delete(); m_bits.delete();
        end else if (armed) begin
            // fetch sees the state before this edge
            e_valid = fetch_req;
            if (fetch_req)
                e_data = (!e_loading && int'(fetch_addr) < e_plen) ? 4'(m_com[fetch_addr]) : NOP;
            if (load_start) begin
                e_loading = 1; e_full = 0;
                m_words.delete(); m_bits.delete();
            end else if (e_loading && load_done) begin
                e_loading = 0;
                e_plen    = m_words.size();
                foreach (m_words[i]) m_com[i] = m_words[i];
                m_bits.delete();
            end else if (e_loading && load_strobe && m_words.size() < DEPTH) begin
                m_bits.push_back(int'(load_bit));
                if (m_bits.size() == DW) begin
                    int w;
                    w = 0;
                    foreach (m_bits[i]) w = w * 2 + m_bits[i];
                    m_words.push_back(w);
                    m_bits.delete();
                end
                e_full = (m_words.size() == DEPTH);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("loading",     loading,     e_loading);
            chk("load_full",   load_full,   e_full);
            chk("prog_len",    prog_len,    e_plen);
            chk("fetch_valid", fetch_valid, e_valid);
            chk("fetch_data",  fetch_data,  e_data);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1; tick(); load_start = 0;
    endtask

    task automatic pulse_done();
        load_done = 1; tick(); load_done = 0;
    endtask

    task automatic send_bits(input logic [3:0] w, input int nbits);
        for (int b = DW - 1; b >= DW - nbits; b--) begin
            load_strobe = 1; load_bit = w[b]; tick();
        end
        load_strobe = 0; load_bit = 0;
    endtask

    task automatic fetch(input int a, input logic [3:0] exp, input string nm);
        logic [31:0] av;
        av = a;
        fetch_req = 1; fetch_addr = av[AW-1:0]; tick();
        fetch_req = 0;
        chk({nm, "_valid"}, fetch_valid, 1);
        chk(nm, fetch_data, exp);
    endtask

    initial begin
        // Reset and empty-store reads
        rst = 1; tick(); tick(); rst = 0;
        chk("rst_loading", loading, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_data", fetch_data, 4'b0111);
        fetch(0,   4'b0111, "empty_a0");
        fetch(5,   4'b0111, "empty_a5");
        fetch(255, 4'b0111, "empty_a255");
        tick();
        chk("valid_drop", fetch_valid, 0);

        // Strobes and load_done in IDLE are ignored
        send_bits(4'b1111, 4);
        pulse_done();
        chk("idle_done_plen", prog_len, 0);

        // Three-word program
        pulse_start();
        chk("start_loading", loading, 1);
        send_bits(4'b0000, 4);
        send_bits(4'b0001, 4);
        send_bits(4'b0100, 4);
        pulse_done();
        chk("three_plen", prog_len, 3);
        chk("three_loading", loading, 0);
        fetch(0, 4'b0000, "three_a0");
        fetch(1, 4'b0001, "three_a1");
        fetch(2, 4'b0100, "three_a2");
        fetch(3, 4'b0111, "three_a3");

        // load_start and load_done together: start wins
        load_start = 1; load_done = 1; tick(); load_start = 0; load_done = 0;
        chk("start_wins", loading, 1);
        pulse_done();
        chk("empty_commit", prog_len, 0);

        // Fill: 33 words, the last one dropped
        pulse_start();
        for (int i = 0; i < 31; i++) send_bits(4'(i % 16), 4);
        chk("full_early", load_full, 0);
        send_bits(4'(31 % 16), 4);
        chk("full_set", load_full, 1);
        send_bits(4'(32 % 16), 4);
        pulse_done();
        chk("full_plen", prog_len, 32);
        fetch(31,  4'b1111, "full_a31");
        fetch(32,  4'b0111, "full_a32");
        fetch(16,  4'b0000, "full_a16");
        fetch(200, 4'b0111, "full_a200");

        // Partial trailing word is discarded
        pulse_start();
        send_bits(4'b1010, 4);
        send_bits(4'b1100, 2);
        pulse_done();
        chk("partial_plen", prog_len, 1);
        fetch(0, 4'b1010, "partial_a0");
        fetch(1, 4'b0111, "partial_a1");

        // Fetch during LOAD, then reset mid-load
        pulse_start();
        fetch(0, 4'b0111, "during_load");
        send_bits(4'b0011, 4);
        send_bits(4'b0101, 4);
        rst = 1; tick(); rst = 0;
        chk("midrst_loading", loading, 0);
        chk("midrst_plen", prog_len, 0);
        fetch(0, 4'b0111, "midrst_a0");
        fetch(1, 4'b0111, "midrst_a1");

        // Reload: shorter program hides stale words
        pulse_start();
        for (int i = 1; i <= 5; i++) send_bits(4'(i), 4);
        pulse_done();
        chk("five_plen", prog_len, 5);
        fetch(3, 4'b0100, "five_a3");
        pulse_start();
        send_bits(4'b1001, 4);
        send_bits(4'b1000, 4);
        pulse_done();
        chk("reload_plen", prog_len, 2);
        fetch(0, 4'b1001, "reload_a0");
        fetch(1, 4'b1000, "reload_a1");
        fetch(3, 4'b0111, "reload_a3");
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/program_store.md
Name: program_store

Overview:
- Parametrised, field-loadable successor to the fixed opcode ROM. Holds up to DEPTH opcodes of DATA_WIDTH bits each.
- Opcodes are loaded bit-serially from the SPI-side loader. The CPU fetch unit reads them with a registered, 1-cycle-latency port.
- Any address that is unloaded or out of range returns NOP_OPCODE (CLR). A short program therefore falls through to NOPs.

Parameters:
- ADDR_WIDTH, 8, width of fetch_addr.
- DATA_WIDTH, 4, opcode width in bits.
- DEPTH, 32, number of storage words; must be ≤ 2**ADDR_WIDTH and ≥ 2.
- NOP_OPCODE, 4'b0111, opcode returned for unloaded or out-of-range reads (width DATA_WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  pulse: begin a new program load.
- load_strobe  input  1  qualifies load_bit; one bit accepted per cycle when high.
- load_bit  input  1  serial opcode bit, MSB first.
- load_done  input  1  pulse: end load, commit program length.
- loading  output  1  high between load_start and load_done.
- load_full  output  1  high once DEPTH words have been written in the current load.
- prog_len  output  $clog2(DEPTH)+1  number of committed words.
- fetch_req  input  1  read request.
- fetch_addr  input  ADDR_WIDTH  read address.
- fetch_valid  output  1  fetch_data valid; registered version of fetch_req.
- fetch_data  output  DATA_WIDTH  opcode.

Behaviour:
- Reset (rst=1 at a clock edge):
  - loading=0, load_full=0, prog_len=0, fetch_valid=0, fetch_data=NOP_OPCODE.
  - Write pointer, bit counter and shift register cleared.
  - Storage array is not reset; prog_len=0 makes every word read as NOP.
  - Reset mid-load abandons the load; nothing is committed.
- Controller FSM states: IDLE, LOAD.
  - IDLE→LOAD on load_start. Clears write pointer, bit counter, shift register and load_full. Sets loading=1. prog_len is held until commit.
  - load_start while already in LOAD restarts the load, with the same clears.
  - LOAD→IDLE on load_done. Commits prog_len = write pointer and drops loading.
  - A partially shifted word (bit counter ≠ 0) is discarded at load_done.
  - load_done in IDLE is ignored.
  - load_start and load_done in the same cycle: load_start wins.
- Shifting, in LOAD with load_strobe=1:
  - shift register = {shift[DATA_WIDTH-2:0], load_bit}, bit counter increments.
  - On the DATA_WIDTH-th bit, the assembled word (including the bit of that cycle) is written to mem[write pointer] the same cycle. Write pointer increments, bit counter returns to 0.
  - If write pointer == DEPTH: the write is dropped, load_full=1, and further bits are ignored until the next load_start.
  - load_strobe in IDLE is ignored.
- Fetch path:
  - fetch_valid(t+1) = fetch_req(t).
  - When fetch_req(t)=1, fetch_data(t+1) is:
    - mem[fetch_addr] if fetch_addr < prog_len and loading=0;
    - NOP_OPCODE otherwise. This covers fetch_addr ≥ DEPTH and any fetch during LOAD.
  - When fetch_req=0, fetch_data holds its previous value.
  - Reads use committed prog_len only. A same-cycle commit affects reads from the next cycle.
- Arithmetic:
  - Address compare is unsigned, zero-extended to the wider of ADDR_WIDTH and the prog_len width.
  - No wrap-around: the write pointer saturates at DEPTH.

Test Plan:
- Reset, then fetch addresses 0, 5 and 255 → fetch_valid one cycle after each request, fetch_data = 4'b0111 each time; prog_len = 0.
- Load 0000, 0001, 0100 (12 strobed bits, MSB first), then load_done → prog_len = 3. Fetches of addresses 0, 1, 2, 3 return 0000, 0001, 0100, 0111.
- Load 33 words with word i = i mod 16 → load_full = 1 after the 32nd word, the 33rd is dropped, prog_len = 32. Address 31 returns 1111; address 32 returns 0111.
- Partial word: load 1 word plus 2 extra bits, then load_done → prog_len = 1. Address 1 returns 0111.
- Fetch address 0 during LOAD → 0111. Assert rst mid-load after 2 words → loading = 0, prog_len = 0, all fetches return 0111.
- Reload: load 5 words, commit, then load_start and 2 words, commit → prog_len = 2. Address 3 returns 0111 even though old data remains in the array.
